// File: rtl/layer_sequencer.sv
// layer_sequencer: walks the CNN core through a table of up to 8 layer
// descriptors, firing a one-cycle start per layer and waiting for the
// matching done edge, with per-layer timeout and host abort.
module layer_sequencer #(
  parameter int N_DESC  = 8,
  parameter int TIMEOUT = 2_000_000,
  parameter int DONE_W  = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_idx,
  input  logic [27:0]       cfg_data,
  input  logic [3:0]        n_layers,
  input  logic              run,
  input  logic              abort,
  input  logic [DONE_W-1:0] done,
  output logic [1:0]        start,
  output logic [1:0]        nth_conv_o,
  output logic [4:0]        ofmap_size_o,
  output logic [5:0]        ifmap_ch_o,
  output logic [6:0]        in_node_num_o,
  output logic [6:0]        out_node_num_o,
  output logic              busy,
  output logic [2:0]        cur_layer,
  output logic              seq_done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, SETUP, FIRE, WAIT} state_t;

  localparam logic [23:0] TMAX  = 24'(TIMEOUT - 1);
  localparam logic [3:0]  NMAX  = 4'(N_DESC);

  state_t      state, state_n;
  logic [27:0] tbl [N_DESC];
  logic [1:0]  done_r, done_q;
  logic [23:0] tcnt;
  logic [3:0]  n_lat, n_clamp;
  logic        kind;
  logic        done_edge, last;
  logic        accept, zero_run, complete, tmo;
  logic        load;
  logic [27:0] desc_sel;
  logic        unused_done;

  // only the conv/fc completion bits matter to the sequencer
  assign unused_done = ^done[DONE_W-1:2];

  assign n_clamp   = (n_layers > NMAX) ? NMAX : n_layers;
  assign done_edge = done_r[kind] & ~done_q[kind];
  assign last      = ({1'b0, cur_layer} == (n_lat - 4'd1));
  assign load      = accept | (complete & ~last);
  assign desc_sel  = accept ? tbl[0] : tbl[cur_layer + 3'd1];

  // descriptor table: host writes only land while idle, never reset
  always_ff @(posedge clk) begin
    if (cfg_we && state == IDLE) tbl[cfg_idx] <= cfg_data;
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // next-state and sequencing events; abort overrides completion/timeout
  always_comb begin
    state_n  = state;
    accept   = 1'b0;
    zero_run = 1'b0;
    complete = 1'b0;
    tmo      = 1'b0;
    case (state)
      IDLE: if (run) begin
        if (n_clamp != 4'd0) begin
          accept  = 1'b1;
          state_n = SETUP;
        end else begin
          zero_run = 1'b1;
        end
      end
      SETUP: state_n = FIRE;
      FIRE:  state_n = WAIT;
      WAIT: begin
        if (done_edge) begin
          complete = 1'b1;
          state_n  = last ? IDLE : SETUP;
        end else if (tcnt == TMAX) begin
          tmo     = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (state != IDLE && abort) begin
      state_n  = IDLE;
      complete = 1'b0;
      tmo      = 1'b0;
    end
  end

  // registered outputs, done history, timeout counter and layer bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      start          <= '0;
      nth_conv_o     <= '0;
      ofmap_size_o   <= '0;
      ifmap_ch_o     <= '0;
      in_node_num_o  <= '0;
      out_node_num_o <= '0;
      busy           <= 1'b0;
      cur_layer      <= '0;
      seq_done       <= 1'b0;
      err            <= 1'b0;
      done_r         <= '0;
      done_q         <= '0;
      tcnt           <= '0;
      n_lat          <= '0;
      kind           <= 1'b0;
    end else begin
      done_r   <= done[1:0];
      done_q   <= done_r;
      busy     <= (state_n != IDLE);
      seq_done <= zero_run | (complete & last);
      start    <= (state_n == FIRE) ? (kind ? 2'b10 : 2'b01) : 2'b00;
      if (state == FIRE)      tcnt <= '0;
      else if (state == WAIT) tcnt <= tcnt + 24'd1;
      if (accept) begin
        n_lat     <= n_clamp;
        cur_layer <= '0;
      end else if (complete & ~last) begin
        cur_layer <= cur_layer + 3'd1;
      end
      if (load) begin
        kind           <= desc_sel[0];
        nth_conv_o     <= desc_sel[2:1];
        ofmap_size_o   <= desc_sel[7:3];
        ifmap_ch_o     <= desc_sel[13:8];
        in_node_num_o  <= desc_sel[20:14];
        out_node_num_o <= desc_sel[27:21];
      end
      if (accept | zero_run) err <= 1'b0;
      else if (tmo)          err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: directed scenarios plus randomized descriptor
// programs, checked against a table-level model of the expected sequence.
module tb_layer_sequencer;

  localparam int DONE_W = 17;
  localparam int TMO    = 100;

  logic              clk = 1'b0;
  logic              rst, cfg_we, run, abort;
  logic [2:0]        cfg_idx;
  logic [27:0]       cfg_data;
  logic [3:0]        n_layers;
  logic [DONE_W-1:0] done;
  logic [1:0]        start, nth_conv_o;
  logic [4:0]        ofmap_size_o;
  logic [5:0]        ifmap_ch_o;
  logic [6:0]        in_node_num_o, out_node_num_o;
  logic              busy, seq_done, err;
  logic [2:0]        cur_layer;

  int vectors = 0;
  int miscompares = 0;
  logic [27:0] tbl_m [8];

  layer_sequencer #(.N_DESC(8), .TIMEOUT(TMO), .DONE_W(DONE_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .n_layers(n_layers), .run(run), .abort(abort), .done(done),
    .start(start), .nth_conv_o(nth_conv_o), .ofmap_size_o(ofmap_size_o),
    .ifmap_ch_o(ifmap_ch_o), .in_node_num_o(in_node_num_o),
    .out_node_num_o(out_node_num_o), .busy(busy), .cur_layer(cur_layer),
    .seq_done(seq_done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [26:0] cfg_out();
    return {out_node_num_o, in_node_num_o, ifmap_ch_o, ofmap_size_o, nth_conv_o};
  endfunction

  task automatic wr(input int idx, input logic [27:0] data);
    cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_data = data;
    step();
    cfg_we = 1'b0;
    tbl_m[idx] = data;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_start"}, start, 0);
    chk({tag, "_cfg"}, cfg_out(), 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_layer"}, cur_layer, 0);
    chk({tag, "_seqdone"}, seq_done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  // One whole run: n layers requested, done raised lat cycles after each
  // start (lat 0 = random). hold keeps done high across a layer boundary.
  task automatic do_run(input int n, input int lat_fix, input bit hold);
    int cnt, lat;
    bit k, held;
    cnt = (n > 8) ? 8 : n;
    held = 1'b0;
    run = 1'b1; n_layers = 4'(n);
    step();
    run = 1'b0;
    if (cnt == 0) begin
      chk("zero_seqdone", seq_done, 1);
      chk("zero_busy", busy, 0);
      chk("zero_err", err, 0);
      step();
      chk("zero_seqdone_off", seq_done, 0);
      chk("zero_start", start, 0);
      return;
    end
    for (int i = 0; i < cnt; i++) begin
      k = tbl_m[i][0];
      chk("setup_busy", busy, 1);
      chk("setup_err", err, 0);
      chk("setup_layer", cur_layer, 32'(i));
      chk("setup_cfg", cfg_out(), tbl_m[i][27:1]);
      chk("setup_start", start, 0);
      chk("setup_seqdone", seq_done, 0);
      step();
      chk("fire_start", start, k ? 2 : 1);
      chk("fire_cfg", cfg_out(), tbl_m[i][27:1]);
      step();
      chk("wait_start", start, 0);
      if (held) begin
        for (int j = 0; j < 10; j++) begin
          step();
          chk("held_layer", cur_layer, 32'(i));
          chk("held_start", start, 0);
        end
        done[1:0] = 2'b00;
        held = 1'b0;
        step(); step();
      end
      lat = (lat_fix != 0) ? lat_fix : $urandom_range(3, 60);
      for (int j = 1; j < lat; j++) begin
        step();
        chk("lat_start", start, 0);
        chk("lat_busy", busy, 1);
      end
      done[k] = 1'b1;
      step();
      chk("det_pending_layer", cur_layer, 32'(i));
      chk("det_pending_busy", busy, 1);
      step();
      if (hold && i < cnt - 1) held = 1'b1;
      else done[1:0] = 2'b00;
      if (i == cnt - 1) begin
        chk("end_seqdone", seq_done, 1);
        chk("end_busy", busy, 0);
        chk("end_start", start, 0);
        step();
        chk("end_seqdone_off", seq_done, 0);
        chk("end_cfg_hold", cfg_out(), tbl_m[cnt-1][27:1]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_data = '0;
    n_layers = '0; run = 1'b0; abort = 1'b0; done = '0;
    step(); step();
    chk_reset_outs("reset");
    rst = 1'b0;
    step();

    // single conv layer, done 50 cycles after start
    wr(0, 28'((1 << 8) | (28 << 3)));
    do_run(1, 50, 1'b0);

    // three layers: conv, conv, fc
    wr(1, 28'((6 << 8) | (10 << 3) | (1 << 1)));
    wr(2, 28'((84 << 21) | (120 << 14) | 1));
    do_run(3, 0, 1'b0);

    // done[0] still high when the next conv layer enters WAIT
    do_run(2, 20, 1'b1);

    // timeout: no done at all
    run = 1'b1; n_layers = 4'd1;
    step();
    run = 1'b0;
    step();
    chk("tmo_fire", start, 1);
    for (int j = 1; j <= TMO; j++) begin
      step();
      if (j == TMO) begin
        chk("tmo_err_before", err, 0);
        chk("tmo_busy_before", busy, 1);
      end
    end
    step();
    chk("tmo_err", err, 1);
    chk("tmo_busy", busy, 0);
    chk("tmo_seqdone", seq_done, 0);
    step();
    chk("tmo_err_sticky", err, 1);
    do_run(0, 0, 1'b0);

    // abort coinciding with a done edge; table write while busy is dropped
    run = 1'b1; n_layers = 4'd2;
    step();
    run = 1'b0;
    step(); step();
    for (int j = 0; j < 5; j++) step();
    cfg_we = 1'b1; cfg_idx = 3'd0; cfg_data = 28'h5a5a5a5;
    step();
    cfg_we = 1'b0;
    done[0] = 1'b1;
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_seqdone", seq_done, 0);
    chk("abort_start", start, 0);
    chk("abort_err", err, 0);
    for (int j = 0; j < 5; j++) begin
      step();
      chk("post_abort_start", start, 0);
      chk("post_abort_seqdone", seq_done, 0);
    end
    done[0] = 1'b0;
    step(); step();
    do_run(1, 0, 1'b0);

    // reset in the middle of WAIT
    run = 1'b1; n_layers = 4'd3;
    step();
    run = 1'b0;
    for (int j = 0; j < 6; j++) step();
    rst = 1'b1;
    step();
    chk_reset_outs("midrst");
    rst = 1'b0;
    step();
    chk_reset_outs("midrst_after");

    // randomized programs, counts 1..9 (9 clamps to 8), noise on unused done bits
    for (int r = 0; r < 6; r++) begin
      done[DONE_W-1:2] = 15'($urandom);
      for (int d = 0; d < 8; d++) wr(d, 28'($urandom));
      do_run($urandom_range(1, 9), 0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Sequences the CNN accelerator core through a programmable list of up to 8 layer descriptors. For each layer it drives the core's configuration inputs (`start`, `nth_conv_i`, `ofmap_size_i`, `ifmap_ch_i`, `in_node_num_i`, `out_node_num_i`), fires a one-cycle start, and waits for the matching `done` bit. A per-layer timeout, an abort input and status outputs let the host run a whole network (conv, pool-fused conv, fc) with one `run` pulse. It sits between the host register interface and `top_wrapped`'s control inputs.

## Interface
- `N_DESC`, 8: descriptor table depth (index width 3).
- `TIMEOUT`, 2_000_000: max cycles in WAIT per layer before error; counter width 24.
- `DONE_W`, 17: width of core `done` bus.

- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `cfg_we` in 1: write descriptor `cfg_idx` with `cfg_data`; ignored while `busy`=1.
- `cfg_idx` in 3: descriptor index.
- `cfg_data` in 28: [0] kind (0 conv, 1 fc), [2:1] nth_conv, [7:3] ofmap_size, [13:8] ifmap_ch, [20:14] in_node, [27:21] out_node.
- `n_layers` in 4: number of descriptors to run (0..8); sampled on accepted `run`.
- `run` in 1: start sequence; ignored while `busy`=1.
- `abort` in 1: stop sequence.
- `done` in `DONE_W`: core completion flags; bit 0 = conv layer done, bit 1 = fc layer done, others ignored.
- `start` out 2: to core; bit 0 conv start, bit 1 fc start.
- `nth_conv_o` out 2, `ofmap_size_o` out 5, `ifmap_ch_o` out 6, `in_node_num_o` out 7, `out_node_num_o` out 7: core configuration.
- `busy` out 1: sequence in progress.
- `cur_layer` out 3: index of layer being executed.
- `seq_done` out 1: one-cycle pulse when all layers complete.
- `err` out 1: sticky timeout flag, cleared by next accepted `run` or `rst`.

## Operation
- States: IDLE, SETUP, FIRE, WAIT.
- Descriptor table: 8×28 registers, not reset (contents undefined after power-up until written); written only in IDLE.
- IDLE: on `run`=1 with `n_layers`≥1 (values >8 clamp to 8): latch count, `cur_layer`←0, load config outputs from table[0], `busy`←1, `err`←0, → SETUP. With `n_layers`=0: `seq_done` pulses next cycle, `err`←0, stay IDLE.
- SETUP: config outputs stable; → FIRE.
- FIRE: `start[kind]`=1 for exactly this one cycle; `timeout_cnt`←0; → WAIT.
- WAIT: completion = rising edge of `done[kind]` (`done` registered once; edge = `done_r & ~done_q`). Level already high on WAIT entry does not count. On completion: last layer → IDLE, `busy`←0, `seq_done` pulse; else `cur_layer`+1, load next descriptor, → SETUP. If `timeout_cnt` reaches `TIMEOUT`-1 with no completion → IDLE, `err`←1, `busy`←0, no `seq_done`.
- Config outputs hold their last values in IDLE until the next load.
- `abort`=1 in any non-IDLE state → IDLE next edge, `start`=0, `busy`←0, no `seq_done`, `err` unchanged. `abort` beats completion and timeout in the same cycle.
- fc descriptors drive `nth_conv_o` from the field too; the core ignores it.

## Timing
- Reset: `start`=0, all config outputs 0, `busy`=0, `cur_layer`=0, `seq_done`=0, `err`=0, state IDLE, `done` history 0. Reset mid-sequence returns to IDLE with no pulse.
- `run` sampled at edge E0 → config valid and `busy`=1 after E0; `start` high between E1 and E2; WAIT from E2.
- `done` edge arriving at the input in cycle k is detected at edge k+2 (one register, then edge compare). Next layer's `start` fires 2 cycles after that. `seq_done` is high for the cycle after detection.
- Minimum per-layer overhead: 4 cycles plus core latency.
- All outputs registered; no combinational path from inputs to outputs.

## Test plan
- Program desc0={conv,nth0,28,1}, n_layers=1, run; model raises done[0] 50 cycles after start → exactly one start=2'b01 pulse with ofmap=28, ch=1 held; seq_done pulse once; busy falls the same cycle.
- Three layers {conv nth0 28/1, conv nth1 10/6, fc in120 out84} → start pulses 01,01,10 in order; cur_layer 0,1,2; config outputs switch only in SETUP.
- done[0] held high from the previous layer into WAIT → no advance until done[0] drops and re-rises.
- TIMEOUT=100, no done → err=1 exactly 100 WAIT cycles after start, busy=0, no seq_done; next run clears err.
- abort during WAIT with a simultaneous done edge → IDLE, no seq_done, no further start; cfg_we while busy → table unchanged (verify on next run).
- n_layers=0 run → seq_done pulse, start never asserted; rst asserted mid-WAIT → all outputs return to reset values next edge.
